// File: rtl/shift_add_multiplier_if.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier_if
// Handshake bundle for the sequential shift-add multiplier.
//   in_valid / in_ready   : operand transfer (in_1 multiplicand, in_2 multiplier)
//   out_valid / out_ready : product transfer (product, 2*SIZE bits)
// slave  : the multiplier side (accepts operands, offers the product)
// master : the client side (offers operands, accepts the product)
// SIZE must match the SIZE of the multiplier the interface is bound to.
// ----------------------------------------------------------------------------
interface shift_add_multiplier_if #(
   parameter int SIZE = 4
);
   logic                in_valid;
   logic                in_ready;
   logic [SIZE-1:0]     in_1;
   logic [SIZE-1:0]     in_2;
   logic                out_valid;
   logic                out_ready;
   logic [2*SIZE-1:0]   product;

   modport master (
      output in_valid, in_1, in_2, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, in_1, in_2, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// ----------------------------------------------------------------------------
// shift_add_multiplier
// Sequential unsigned SIZE x SIZE multiplier. One conditional add of the
// multiplicand per cycle through a single SIZE-bit ripple adder (n_fulladdr),
// followed by a right shift of {C,A,Q}. The exact 2*SIZE-bit product is
// offered on a valid/ready handshake.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : shift_add_multiplier_if.slave (operand and product handshakes)
//   busy  : high while iterating
// Latency: accept edge = cycle 0, SIZE iteration cycles, out_valid in
// cycle SIZE+1. One product per SIZE+2 cycles with out_ready held high.
// ----------------------------------------------------------------------------

// SIZE-bit ripple-carry adder.
module n_fulladdr #(
   parameter int SIZE = 4
) (
   input  logic [SIZE-1:0] in_1,
   input  logic [SIZE-1:0] in_2,
   input  logic            carry_in,
   output logic [SIZE-1:0] sum,
   output logic            carry_out
);
   always_comb begin
      logic c;
      c   = carry_in;
      sum = '0;
      for (int i = 0; i < SIZE; i++) begin
         sum[i] = in_1[i] ^ in_2[i] ^ c;
         c      = (in_1[i] & in_2[i]) | (c & (in_1[i] ^ in_2[i]));
      end
      carry_out = c;
   end
endmodule

// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand pair
// CALC  | busy, one add-and-shift per cycle for SIZE cycles
// DONE  | out_valid high, product held until out_ready
module shift_add_multiplier #(
   parameter  int SIZE = 4,
   localparam int CW   = $clog2(SIZE + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   shift_add_multiplier_if.slave   bus,
   output logic                    busy
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [SIZE-1:0]     r_m;
   logic [SIZE-1:0]     r_a;
   logic [SIZE-1:0]     r_q;
   logic                r_c;
   logic [CW-1:0]       r_count;
   logic [2*SIZE-1:0]   r_product;

   logic [SIZE-1:0]     w_addend;
   logic [SIZE-1:0]     w_sum;
   logic                w_cout;
   logic [SIZE-1:0]     w_a_nxt;
   logic [SIZE-1:0]     w_q_nxt;
   logic                w_last;

   assign w_addend = r_q[0] ? r_m : '0;

   // C is cleared on load and the shift moves the adder carry into A's MSB,
   // so C is always 0 here: this is the same as a tied-low carry-in.
   n_fulladdr #(.SIZE(SIZE)) u_add (
      .in_1      (r_a),
      .in_2      (w_addend),
      .carry_in  (r_c),
      .sum       (w_sum),
      .carry_out (w_cout)
   );

   // {C,A,Q} <= {0, carry_out, sum, Q} >> 1
   assign w_a_nxt = {w_cout, w_sum[SIZE-1:1]};
   assign w_q_nxt = {w_sum[0], r_q[SIZE-1:1]};
   assign w_last  = (r_count == CW'(SIZE - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (bus.in_valid)  w_state_nxt = CALC;
         CALC:    if (w_last)        w_state_nxt = DONE;
         DONE:    if (bus.out_ready) w_state_nxt = IDLE;
         default:                    w_state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decode the state register only.
   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign busy          = (r_state == CALC);
   assign bus.product   = r_product;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m       <= '0;
         r_a       <= '0;
         r_q       <= '0;
         r_c       <= 1'b0;
         r_count   <= '0;
         r_product <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_m     <= bus.in_1;
                  r_q     <= bus.in_2;
                  r_a     <= '0;
                  r_c     <= 1'b0;
                  r_count <= '0;
               end
            end
            CALC: begin
               r_c     <= 1'b0;
               r_a     <= w_a_nxt;
               r_q     <= w_q_nxt;
               r_count <= r_count + 1'b1;
               if (w_last) r_product <= {w_a_nxt, w_q_nxt};
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4, rst8;
   logic busy4, busy8;

   shift_add_multiplier_if #(.SIZE(4)) b4();
   shift_add_multiplier_if #(.SIZE(8)) b8();

   shift_add_multiplier #(.SIZE(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(b4), .busy(busy4));
   shift_add_multiplier #(.SIZE(8)) u_dut8 (.clk(clk), .rst(rst8), .bus(b8), .busy(busy8));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   longint exp4_q[$];
   int     acc4_q[$];
   longint exp8_q[$];
   int     acc8_q[$];

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor, SIZE=4 ----------------
   logic       prev_v4 = 1'b0;
   logic       hs4     = 1'b0;
   logic [7:0] held4   = '0;
   int         busy_n4 = 0;

   always @(negedge clk) begin
      if (rst4) begin
         prev_v4 = 1'b0; hs4 = 1'b0; busy_n4 = 0;
      end else begin
         if (hs4) check("in_ready_after_take4", b4.in_ready, 1);
         hs4 = 1'b0;
         if (busy4) begin
            busy_n4++;
            check("in_ready_in_calc4", b4.in_ready, 0);
         end
         if (b4.out_valid) begin
            check("in_ready_in_done4", b4.in_ready, 0);
            if (!prev_v4) begin
               if (acc4_q.size() == 0) flag("unexpected_out_valid4");
               else check("latency4", cyc - acc4_q[0], 5);
               check("busy_cycles4", busy_n4, 4);
               busy_n4 = 0;
               held4 = b4.product;
            end else begin
               check("product_stable4", b4.product, held4);
            end
            if (b4.out_ready) begin
               if (exp4_q.size() == 0) flag("spurious_product4");
               else begin
                  check("product4", b4.product, exp4_q.pop_front());
                  void'(acc4_q.pop_front());
               end
               hs4 = 1'b1;
            end
         end
         prev_v4 = b4.out_valid && !b4.out_ready;
      end
   end

   // ---------------- monitor, SIZE=8 ----------------
   logic        prev_v8 = 1'b0;
   logic [15:0] held8   = '0;

   always @(negedge clk) begin
      if (rst8) begin
         prev_v8 = 1'b0;
      end else begin
         if (b8.out_valid) begin
            if (!prev_v8) begin
               if (acc8_q.size() == 0) flag("unexpected_out_valid8");
               else check("latency8", cyc - acc8_q[0], 9);
               held8 = b8.product;
            end else begin
               check("product_stable8", b8.product, held8);
            end
            if (b8.out_ready) begin
               if (exp8_q.size() == 0) flag("spurious_product8");
               else begin
                  check("product8", b8.product, exp8_q.pop_front());
                  void'(acc8_q.pop_front());
               end
            end
         end
         prev_v8 = b8.out_valid && !b8.out_ready;
      end
   end

   logic rnd_ready8 = 1'b0;
   always @(posedge clk) begin
      #1;
      if (rnd_ready8) b8.out_ready = ($urandom_range(0, 3) != 0);
   end

   // ---------------- stimulus helpers ----------------
   task automatic send4(input logic [3:0] a, input logic [3:0] b, output int acc);
      int guard = 0;
      b4.in_1 = a; b4.in_2 = b; b4.in_valid = 1'b1;
      while (!b4.in_ready && guard < 50) begin tick(); guard++; end
      acc = cyc;
      if (!b4.in_ready) begin
         flag("send4_timeout_in_ready_stuck_low");
         b4.in_valid = 1'b0;
         return;
      end
      exp4_q.push_back(longint'(a) * longint'(b));
      acc4_q.push_back(cyc);
      tick();
      b4.in_valid = 1'b0;
   endtask

   task automatic send8(input logic [7:0] a, input logic [7:0] b);
      int guard = 0;
      b8.in_1 = a; b8.in_2 = b; b8.in_valid = 1'b1;
      while (!b8.in_ready && guard < 60) begin tick(); guard++; end
      if (!b8.in_ready) begin
         flag("send8_timeout_in_ready_stuck_low");
         b8.in_valid = 1'b0;
         return;
      end
      exp8_q.push_back(longint'(a) * longint'(b));
      acc8_q.push_back(cyc);
      tick();
      b8.in_valid = 1'b0;
   endtask

   task automatic drain4();
      int guard = 0;
      while (exp4_q.size() != 0 && guard < 100) begin tick(); guard++; end
      if (exp4_q.size() != 0) flag("drain4_timeout_product_never_delivered");
      tick();
   endtask

   task automatic drain8();
      int guard = 0;
      while (exp8_q.size() != 0 && guard < 200) begin tick(); guard++; end
      if (exp8_q.size() != 0) flag("drain8_timeout_product_never_delivered");
      tick();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int a0, a1, a2, a3, acc, guard;
      rst4 = 1'b1; rst8 = 1'b1;
      b4.in_valid = 1'b0; b4.in_1 = '0; b4.in_2 = '0; b4.out_ready = 1'b0;
      b8.in_valid = 1'b0; b8.in_1 = '0; b8.in_2 = '0; b8.out_ready = 1'b0;
      tick(); tick();

      check("reset_in_ready4",  b4.in_ready,  1);
      check("reset_out_valid4", b4.out_valid, 0);
      check("reset_busy4",      busy4,        0);
      check("reset_product4",   b4.product,   0);
      check("reset_in_ready8",  b8.in_ready,  1);
      check("reset_out_valid8", b8.out_valid, 0);
      check("reset_product8",   b8.product,   0);
      rst4 = 1'b0; rst8 = 1'b0;
      tick();

      // 15*15: latency, busy length, in_ready return
      b4.out_ready = 1'b1;
      send4(4'd15, 4'd15, acc);
      check("in_ready_drop4", b4.in_ready, 0);
      check("busy_after_accept4", busy4, 1);
      drain4();

      // back-to-back pairs, spacing SIZE+2
      send4(4'd0,  4'd9,  a0);
      send4(4'd9,  4'd0,  a1);
      send4(4'd1,  4'd1,  a2);
      send4(4'd13, 4'd11, a3);
      check("spacing_1", a1 - a0, 6);
      check("spacing_2", a2 - a1, 6);
      check("spacing_3", a3 - a2, 6);
      drain4();

      // 12*10 with a stalled consumer
      b4.out_ready = 1'b0;
      send4(4'd12, 4'd10, acc);
      guard = 0;
      while (!b4.out_valid && guard < 20) begin tick(); guard++; end
      if (!b4.out_valid) flag("stall_wait_out_valid_timeout");
      repeat (7) tick();
      check("stall_out_valid_held", b4.out_valid, 1);
      check("stall_product_held",   b4.product,   120);
      b4.out_ready = 1'b1;
      drain4();
      check("stall_single_transfer", b4.out_valid, 0);

      // reset in the 2nd CALC cycle of 7*6
      send4(4'd7, 4'd6, acc);
      tick();
      rst4 = 1'b1;
      tick();
      rst4 = 1'b0;
      exp4_q.delete(); acc4_q.delete();
      check("midreset_in_ready",  b4.in_ready,  1);
      check("midreset_out_valid", b4.out_valid, 0);
      check("midreset_busy",      busy4,        0);
      check("midreset_product",   b4.product,   0);
      send4(4'd3, 4'd5, acc);
      drain4();

      // operands wiggled while busy must be ignored
      send4(4'd11, 4'd13, acc);
      repeat (5) begin
         b4.in_valid = 1'($urandom_range(0, 1));
         b4.in_1 = 4'($urandom);
         b4.in_2 = 4'($urandom);
         tick();
      end
      b4.in_valid = 1'b0;
      drain4();

      // SIZE=8: corners then random pairs with a random consumer
      rnd_ready8 = 1'b1;
      send8(8'd255, 8'd255);
      send8(8'd0,   8'd200);
      send8(8'd200, 8'd0);
      send8(8'd255, 8'd1);
      for (int i = 0; i < 1000; i++) send8(8'($urandom), 8'($urandom));
      drain8();
      rnd_ready8 = 1'b0;

      check("queue4_empty", exp4_q.size(), 0);
      check("queue8_empty", exp8_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
